// File: rtl/rr_trace_split_pkg.sv
// Shared definitions for the trace replay splitter.
//   PACKET_ALIGNMENT : frame size in bits; every packet, beat and shift is whole frames
//   split_state_e    : splitter FSM states
//   frames_in        : bits -> frame count for elaboration-time constants
//   frames_to_bits   : frame count -> bit count
//   min_frames       : smaller of two frame counts
package rr_trace_split_pkg;

    localparam int PACKET_ALIGNMENT = 32;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2,
        ST_EMIT  = 2'd3
    } split_state_e;

    function automatic int frames_in(input int bits);
        return bits / PACKET_ALIGNMENT;
    endfunction

    function automatic logic [31:0] frames_to_bits(input logic [31:0] frames);
        return frames * 32'(PACKET_ALIGNMENT);
    endfunction

    function automatic logic [31:0] min_frames(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_trace_split_shifter.sv
// Frame-granular move of the low frames of a source word into a destination word.
//   src_i         : leftover beat bits, LSB-aligned
//   dst_i         : packet being assembled
//   take_frames_i : number of frames to move out of src_i
//   dst_frames_i  : frames already present in dst_i (insert offset)
//   src_rest_o    : src_i shifted right by the moved frames
//   dst_o         : dst_i with the moved frames ORed in at the insert offset
// Callers guarantee take_frames_i <= frames in src_i and that the result fits dst_o.
module rr_frame_shifter #(
    parameter int SRC_WIDTH = 512,
    parameter int DST_WIDTH = 2048,
    parameter int CNT_WIDTH = 32,
    parameter int PA        = 32
) (
    input  logic [SRC_WIDTH-1:0] src_i,
    input  logic [DST_WIDTH-1:0] dst_i,
    input  logic [CNT_WIDTH-1:0] take_frames_i,
    input  logic [CNT_WIDTH-1:0] dst_frames_i,
    output logic [SRC_WIDTH-1:0] src_rest_o,
    output logic [DST_WIDTH-1:0] dst_o
);

    localparam logic [CNT_WIDTH-1:0] PA_C = CNT_WIDTH'(PA);

    logic [CNT_WIDTH-1:0] take_bits;
    logic [CNT_WIDTH-1:0] dst_bits;
    logic [DST_WIDTH-1:0] src_ext;
    logic [DST_WIDTH-1:0] take_mask;

    assign take_bits  = take_frames_i * PA_C;
    assign dst_bits   = dst_frames_i * PA_C;
    assign src_ext    = DST_WIDTH'(src_i);
    // Mask is built in the destination width so a full-beat take does not overflow.
    assign take_mask  = ~({DST_WIDTH{1'b1}} << take_bits);
    assign dst_o      = dst_i | ((src_ext & take_mask) << dst_bits);
    assign src_rest_o = src_i >> take_bits;

endmodule

// File: rtl/rr_trace_split.sv
// Re-splits densely packed trace beats read back from DRAM into variable-width packets.
//   clk, sync_rst            : clock, synchronous active-high reset
//   replay_in_fifo_*         : FWFT beat source (data, empty, pop)
//   replay_out_fifo_in       : reassembled packet, LSB-aligned, zero above the packet
//   replay_out_fifo_in_width : packet width in bits
//   replay_out_fifo_wr_en    : one-cycle write strobe
//   replay_out_fifo_almfull  : holds the pending packet while asserted
//   replay_error             : sticky, a header longer than WIDTH was seen
//   replay_pkt_cnt           : packets emitted since reset, wraps
//
// state | meaning
// HDR   | decode header at bottom of leftover beat (len 0 = pad, too long = error)
// FETCH | pop next beat into leftover, then go back to the caller (HDR or FILL)
// FILL  | move min(need, leftover) frames into the packet
// EMIT  | write packet once the output FIFO has room
module rr_trace_split
    import rr_trace_split_pkg::*;
#(
    parameter int WIDTH        = 2048,
    parameter int AXI_WIDTH    = 512,
    parameter int OFFSET_WIDTH = 32,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    sync_rst,
    input  logic [AXI_WIDTH-1:0]    replay_in_fifo_out,
    input  logic                    replay_in_fifo_empty,
    output logic                    replay_in_fifo_rd_en,
    output logic [WIDTH-1:0]        replay_out_fifo_in,
    output logic [OFFSET_WIDTH-1:0] replay_out_fifo_in_width,
    output logic                    replay_out_fifo_wr_en,
    input  logic                    replay_out_fifo_almfull,
    output logic                    replay_error,
    output logic [OFFSET_WIDTH-1:0] replay_pkt_cnt
);

    localparam logic [OFFSET_WIDTH-1:0] BEAT_FRAMES = OFFSET_WIDTH'(frames_in(AXI_WIDTH));
    localparam logic [OFFSET_WIDTH-1:0] MAX_FRAMES  = OFFSET_WIDTH'(frames_in(WIDTH));

    split_state_e            state_q;
    split_state_e            ret_q;
    logic [AXI_WIDTH-1:0]    l_q;
    logic [OFFSET_WIDTH-1:0] l_frames_q;
    logic [WIDTH-1:0]        p_q;
    logic [OFFSET_WIDTH-1:0] p_frames_q;
    logic [OFFSET_WIDTH-1:0] need_q;
    logic [WIDTH-1:0]        out_q;
    logic [OFFSET_WIDTH-1:0] width_q;
    logic                    wr_en_q;
    logic                    err_q;
    logic [OFFSET_WIDTH-1:0] cnt_q;

    logic [OFFSET_WIDTH-1:0] hdr_len;
    logic [OFFSET_WIDTH-1:0] take;
    logic [AXI_WIDTH-1:0]    l_d;
    logic [WIDTH-1:0]        p_d;

    assign hdr_len = OFFSET_WIDTH'(l_q[LEN_WIDTH-1:0]);
    assign take    = OFFSET_WIDTH'(min_frames(32'(need_q), 32'(l_frames_q)));

    rr_frame_shifter #(
        .SRC_WIDTH (AXI_WIDTH),
        .DST_WIDTH (WIDTH),
        .CNT_WIDTH (OFFSET_WIDTH),
        .PA        (PACKET_ALIGNMENT)
    ) u_shifter (
        .src_i         (l_q),
        .dst_i         (p_q),
        .take_frames_i (take),
        .dst_frames_i  (p_frames_q),
        .src_rest_o    (l_d),
        .dst_o         (p_d)
    );

    // Gated with reset so the input FIFO is never popped while the FSM is being cleared.
    assign replay_in_fifo_rd_en = (state_q == ST_FETCH) && !replay_in_fifo_empty && !sync_rst;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= ST_HDR;
            ret_q      <= ST_HDR;
            l_q        <= '0;
            l_frames_q <= '0;
            p_q        <= '0;
            p_frames_q <= '0;
            need_q     <= '0;
            out_q      <= '0;
            width_q    <= '0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_HDR: begin
                    if (l_frames_q == '0) begin
                        ret_q   <= ST_HDR;
                        state_q <= ST_FETCH;
                    end else if (hdr_len == '0) begin
                        // Padding: the rest of this beat carries nothing.
                        l_frames_q <= '0;
                    end else if (hdr_len > MAX_FRAMES) begin
                        err_q      <= 1'b1;
                        l_frames_q <= '0;
                    end else begin
                        need_q     <= hdr_len;
                        p_q        <= '0;
                        p_frames_q <= '0;
                        state_q    <= ST_FILL;
                    end
                end
                ST_FETCH: begin
                    if (!replay_in_fifo_empty) begin
                        l_q        <= replay_in_fifo_out;
                        l_frames_q <= BEAT_FRAMES;
                        state_q    <= ret_q;
                    end
                end
                ST_FILL: begin
                    p_q        <= p_d;
                    l_q        <= l_d;
                    p_frames_q <= p_frames_q + take;
                    need_q     <= need_q - take;
                    l_frames_q <= l_frames_q - take;
                    if (need_q == take) begin
                        state_q <= ST_EMIT;
                    end else begin
                        // need > take means the leftover is exhausted.
                        ret_q   <= ST_FILL;
                        state_q <= ST_FETCH;
                    end
                end
                ST_EMIT: begin
                    if (!replay_out_fifo_almfull) begin
                        out_q   <= p_q;
                        width_q <= OFFSET_WIDTH'(frames_to_bits(32'(p_frames_q)));
                        wr_en_q <= 1'b1;
                        cnt_q   <= cnt_q + OFFSET_WIDTH'(1);
                        state_q <= ST_HDR;
                    end
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    assign replay_out_fifo_in       = out_q;
    assign replay_out_fifo_in_width = width_q;
    assign replay_out_fifo_wr_en    = wr_en_q;
    assign replay_error             = err_q;
    assign replay_pkt_cnt           = cnt_q;

endmodule

// File: tb/tb_rr_trace_split.sv
// Bench for rr_trace_split: a packer model builds beats from packets, a FWFT feeder
// serves them, and a write monitor checks every emitted packet against a scoreboard.
module tb_rr_trace_split;
    import rr_trace_split_pkg::*;

    localparam int WIDTH = 2048;
    localparam int AXI_WIDTH = 512;
    localparam int OW = 32;

    logic                 clk;
    logic                 sync_rst;
    logic [AXI_WIDTH-1:0] replay_in_fifo_out;
    logic                 replay_in_fifo_empty;
    logic                 replay_in_fifo_rd_en;
    logic [WIDTH-1:0]     replay_out_fifo_in;
    logic [OW-1:0]        replay_out_fifo_in_width;
    logic                 replay_out_fifo_wr_en;
    logic                 replay_out_fifo_almfull;
    logic                 replay_error;
    logic [OW-1:0]        replay_pkt_cnt;

    rr_trace_split dut (
        .clk                      (clk),
        .sync_rst                 (sync_rst),
        .replay_in_fifo_out       (replay_in_fifo_out),
        .replay_in_fifo_empty     (replay_in_fifo_empty),
        .replay_in_fifo_rd_en     (replay_in_fifo_rd_en),
        .replay_out_fifo_in       (replay_out_fifo_in),
        .replay_out_fifo_in_width (replay_out_fifo_in_width),
        .replay_out_fifo_wr_en    (replay_out_fifo_wr_en),
        .replay_out_fifo_almfull  (replay_out_fifo_almfull),
        .replay_error             (replay_error),
        .replay_pkt_cnt           (replay_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               width;
    } sb_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [2:0][6:0]  lens;
        logic [2:0][11:0] widths;
    } vec_t;

    sb_t                  sb[$];
    logic [AXI_WIDTH-1:0] beats[$];
    logic [AXI_WIDTH-1:0] acc;
    int                   acc_fr;
    int                   exp_cnt;
    int                   total;
    int                   bad;
    logic                 rand_mode;
    logic                 almfull_req;
    logic                 pop_pend;
    vec_t                 vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packer model: frames laid LSB-first, back to back across beats.
    task automatic put_frame(input logic [31:0] f);
        acc[acc_fr*32 +: 32] = f;
        acc_fr++;
        if (acc_fr == 16) begin
            beats.push_back(acc);
            acc    = '0;
            acc_fr = 0;
        end
    endtask

    task automatic send_pkt(input int len, input int exp_w);
        logic [WIDTH-1:0] pkt;
        logic [31:0]      w;
        sb_t              e;
        pkt = '0;
        for (int f = 0; f < len; f++) begin
            w = $urandom;
            if (f == 0) w[15:0] = len[15:0];
            pkt[f*32 +: 32] = w;
            put_frame(w);
        end
        e.data  = pkt;
        e.width = exp_w;
        sb.push_back(e);
        exp_cnt++;
    endtask

    // Zero frames read as len-0 headers, so the rest of the beat is padding.
    task automatic flush();
        while (acc_fr != 0) put_frame(32'h0);
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || beats.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, 64'(cyc < 4000), 64'd1);
        repeat (6) @(negedge clk);
    endtask

    function automatic vec_t mk(input int n, input int l0, input int l1, input int l2,
                                input int w0, input int w1, input int w2);
        vec_t v;
        v.n         = 3'(n);
        v.lens[0]   = 7'(l0);
        v.lens[1]   = 7'(l1);
        v.lens[2]   = 7'(l2);
        v.widths[0] = 12'(w0);
        v.widths[1] = 12'(w1);
        v.widths[2] = 12'(w2);
        return v;
    endfunction

    // FWFT input FIFO and output almost-full driver.
    initial begin
        replay_in_fifo_empty    = 1'b1;
        replay_in_fifo_out      = '0;
        replay_out_fifo_almfull = 1'b0;
        pop_pend                = 1'b0;
        forever begin
            @(negedge clk);
            pop_pend = replay_in_fifo_rd_en;
            @(posedge clk);
            #1;
            if (pop_pend && beats.size() > 0) void'(beats.pop_front());
            if (beats.size() > 0 && !(rand_mode && $urandom_range(0, 4) == 0)) begin
                replay_in_fifo_empty = 1'b0;
                replay_in_fifo_out   = beats[0];
            end else begin
                replay_in_fifo_empty = 1'b1;
                replay_in_fifo_out   = '0;
            end
            replay_out_fifo_almfull = rand_mode ? ($urandom_range(0, 3) == 0) : almfull_req;
        end
    end

    // Write monitor / scoreboard.
    initial begin
        sb_t e;
        int  df;
        forever begin
            @(negedge clk);
            if (replay_in_fifo_rd_en) chk("rd_while_empty", 64'(replay_in_fifo_empty), 64'd0);
            if (replay_out_fifo_wr_en) begin
                chk("wr_rd_same_cycle", 64'(replay_in_fifo_rd_en), 64'd0);
                chk("unexpected_write", 64'(sb.size() == 0), 64'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pkt_width", 64'(replay_out_fifo_in_width), 64'(e.width));
                    total++;
                    if (replay_out_fifo_in !== e.data) begin
                        bad++;
                        df = 0;
                        for (int f = 63; f >= 0; f--)
                            if (replay_out_fifo_in[f*32 +: 32] !== e.data[f*32 +: 32]) df = f;
                        $display("FAIL pkt_data: frame %0d actual=%08h required=%08h at %0t",
                                 df, replay_out_fifo_in[df*32 +: 32], e.data[df*32 +: 32], $time);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             stall_wr;
        logic             stall_rd;
        logic             saw_wr;
        logic [AXI_WIDTH-1:0] b;
        int               cyc;
        int               cnt0;

        total       = 0;
        bad         = 0;
        exp_cnt     = 0;
        acc         = '0;
        acc_fr      = 0;
        rand_mode   = 1'b0;
        almfull_req = 1'b0;
        sync_rst    = 1'b1;

        vecs[0] = mk(2,  8, 40,  0,  256, 1280,    0);
        vecs[1] = mk(1, 16,  0,  0,  512,    0,    0);
        vecs[2] = mk(1, 64,  0,  0, 2048,    0,    0);
        vecs[3] = mk(3,  1,  1,  1,   32,   32,   32);
        vecs[4] = mk(3, 15,  2, 47,  480,   64, 1504);
        vecs[5] = mk(2, 64,  1,  0, 2048,   32,    0);

        // Reset held with a beat already waiting; then that beat decodes.
        send_pkt(4, 128);
        send_pkt(12, 384);
        flush();
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 64'(replay_in_fifo_rd_en), 64'd0);
        chk("rst_wr_en", 64'(replay_out_fifo_wr_en), 64'd0);
        chk("rst_out_zero", 64'(replay_out_fifo_in == '0), 64'd1);
        chk("rst_width", 64'(replay_out_fifo_in_width), 64'd0);
        chk("rst_error", 64'(replay_error), 64'd0);
        chk("rst_cnt", 64'(replay_pkt_cnt), 64'd0);
        sync_rst = 1'b0;
        wait_drain("one_beat_drain");
        chk("one_beat_cnt", 64'(replay_pkt_cnt), 64'd2);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++)
                send_pkt(int'(vecs[i].lens[j]), int'(vecs[i].widths[j]));
            flush();
            wait_drain("vec_drain");
            chk("vec_cnt", 64'(replay_pkt_cnt), 64'(exp_cnt));
            chk("vec_error", 64'(replay_error), 64'd0);
        end

        // Backpressure: packet parked in EMIT with another beat waiting.
        almfull_req = 1'b1;
        cnt0 = exp_cnt;
        send_pkt(4, 128);
        flush();
        send_pkt(16, 512);
        repeat (8) @(negedge clk);
        stall_wr = 1'b0;
        stall_rd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (replay_out_fifo_wr_en) stall_wr = 1'b1;
            if (replay_in_fifo_rd_en) stall_rd = 1'b1;
        end
        chk("bp_no_wr", 64'(stall_wr), 64'd0);
        chk("bp_no_rd", 64'(stall_rd), 64'd0);
        chk("bp_beat_held", 64'(beats.size()), 64'd1);
        chk("bp_cnt_held", 64'(replay_pkt_cnt), 64'(cnt0));
        almfull_req = 1'b0;
        wait_drain("bp_drain");
        chk("bp_cnt", 64'(replay_pkt_cnt), 64'(exp_cnt));

        // Oversized header: beat dropped, error sticky, next beat decodes.
        b = '0;
        for (int f = 1; f < 16; f++) b[f*32 +: 32] = $urandom | 32'h1;
        b[31:0] = {16'hABCD, 16'd100};
        beats.push_back(b);
        send_pkt(4, 128);
        send_pkt(3, 96);
        flush();
        wait_drain("badlen_drain");
        chk("badlen_error", 64'(replay_error), 64'd1);
        chk("badlen_cnt", 64'(replay_pkt_cnt), 64'(exp_cnt));

        // Reset while a len-40 packet is only partly delivered.
        b = '0;
        for (int f = 1; f < 16; f++) b[f*32 +: 32] = $urandom;
        b[31:0] = {16'h5A5A, 16'd40};
        beats.push_back(b);
        cyc = 0;
        while (beats.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_beat_taken", 64'(beats.size()), 64'd0);
        saw_wr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (replay_out_fifo_wr_en) saw_wr = 1'b1;
        end
        sync_rst = 1'b1;
        repeat (2) @(negedge clk);
        if (replay_out_fifo_wr_en) saw_wr = 1'b1;
        sync_rst = 1'b0;
        exp_cnt  = 0;
        send_pkt(4, 128);
        flush();
        wait_drain("mid_rst_drain");
        chk("mid_rst_no_partial", 64'(saw_wr), 64'd0);
        chk("mid_rst_cnt", 64'(replay_pkt_cnt), 64'd1);
        chk("mid_rst_error", 64'(replay_error), 64'd0);

        // Random loopback with input gaps and output backpressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int len;
            len = $urandom_range(1, 64);
            send_pkt(len, len * 32);
            if ($urandom_range(0, 5) == 0) flush();
        end
        flush();
        wait_drain("rand_drain");
        rand_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk("rand_cnt", 64'(replay_pkt_cnt), 64'(exp_cnt));
        chk("rand_error", 64'(replay_error), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
